mem_cmd_responder: RTL and testbench

//   Memory-side responder for the IO command interface: takes command, address and write data from
//   the IO controller and executes WRITE/READ/CLEAR on an internal word-addressed RAM. Returns read

---
 rtl/mem_cmd_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_cmd_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_responder.sv
// ---------------------------------------------------------------------------
// mem_cmd_responder
//   Memory-side responder for the IO command interface. Accepts a command
//   from the IO controller on a rising edge of ioCmdDoneIn and runs it against
//   an internal word-addressed RAM. The supported commands are READ, WRITE and
//   CLEAR (zero every word). memCmdDone is the done/busy flag for the
//   handshake: 1 means idle or finished, 0 means busy.
//
// Optional feature macro: MEM_RANGE_ERR_EN
//   When defined, the memErr output and its register exist. memErr flags a
//   READ or WRITE whose address is outside the RAM.
//
// Ports
//   clk          in   1       system clock, rising edge
//   rstN         in   1       asynchronous active-low reset
//   memCmd       in   2       00 NOP, 01 READ, 10 WRITE, 11 CLEAR
//   memAddrIn    in   ADDR_W  word address, sampled on the start edge
//   ioDataIn     in   DATA_W  write data, sampled on the start edge
//   ioCmdDoneIn  in   1       command ready; a rising edge starts a command
//   memCmdDone   out  1       1 = idle/complete, 0 = executing
//   memDataOut   out  DATA_W  read result, held until the next READ or CLEAR
//   memErr       out  1       out-of-range flag (MEM_RANGE_ERR_EN only)
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start edge; the only state that accepts commands
// EXEC   | single cycle that performs the latched READ or WRITE
// CLEAR  | writes one zero word per cycle, DEPTH cycles in total
// ---------------------------------------------------------------------------
module mem_cmd_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic [1:0]        memCmd,
    input  logic [ADDR_W-1:0] memAddrIn,
    input  logic [DATA_W-1:0] ioDataIn,
    input  logic              ioCmdDoneIn,
    output logic              memCmdDone,
`ifdef MEM_RANGE_ERR_EN
    output logic              memErr,
`endif
    output logic [DATA_W-1:0] memDataOut
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [IDX_W:0]    CLR_LAST = (IDX_W+1)'(DEPTH - 1);
    localparam logic [IDX_W:0]    CLR_ONE  = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t              r_state;
    logic [1:0]          r_cmd;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_ioCmdDonePrev;
    logic [IDX_W:0]      r_clearIdx;
    logic                r_cmdDone;
    logic [DATA_W-1:0]   r_dataOut;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_start;
    logic                w_addr_ok;
    logic [IDX_W-1:0]    w_addr_idx;
    logic                w_mem_we;
    logic [IDX_W-1:0]    w_mem_idx;
    logic [DATA_W-1:0]   w_mem_wdata;

    assign w_start    = ioCmdDoneIn & ~r_ioCmdDonePrev;
    // The comparison is on the full address width. An address that has any
    // bit set above the index bits is therefore out of range. The RAM index
    // must not wrap back into range.
    assign w_addr_ok  = (r_addr < DEPTH_A);
    assign w_addr_idx = r_addr[IDX_W-1:0];

    // The RAM write port is driven only from registered state. An async reset
    // forces IDLE at once, so a reset during CLEAR stops the clearing with
    // no further write.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_addr_idx;
        w_mem_wdata = r_data;
        if (r_state == ST_CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_clearIdx[IDX_W-1:0];
            w_mem_wdata = '0;
        end else if (r_state == ST_EXEC && r_cmd == CMD_WRITE && w_addr_ok) begin
            w_mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

`ifdef MEM_RANGE_ERR_EN
    logic r_err;
    logic w_in_addr_ok;

    assign w_in_addr_ok = (memAddrIn < DEPTH_A);
    assign memErr       = r_err;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_start) begin
            if (memCmd == CMD_READ || memCmd == CMD_WRITE) begin
                r_err <= ~w_in_addr_ok;
            end else begin
                r_err <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state         <= ST_IDLE;
            r_cmd           <= '0;
            r_addr          <= '0;
            r_data          <= '0;
            r_ioCmdDonePrev <= 1'b0;
            r_clearIdx      <= '0;
            r_cmdDone       <= 1'b1;
            r_dataOut       <= '0;
        end else begin
            // The edge detector keeps tracking while the block is busy. A
            // level that stays high through completion is then not seen as
            // a new edge.
            r_ioCmdDonePrev <= ioCmdDoneIn;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cmd  <= memCmd;
                        r_addr <= memAddrIn;
                        r_data <= ioDataIn;
                        if (memCmd == CMD_READ || memCmd == CMD_WRITE) begin
                            r_state   <= ST_EXEC;
                            r_cmdDone <= 1'b0;
                        end else if (memCmd == CMD_CLEAR) begin
                            r_state    <= ST_CLEAR;
                            r_clearIdx <= '0;
                            r_cmdDone  <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_cmd == CMD_READ) begin
                        r_dataOut <= w_addr_ok ? r_mem[w_addr_idx] : '0;
                    end
                    r_cmdDone <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_CLEAR: begin
                    r_clearIdx <= r_clearIdx + CLR_ONE;
                    if (r_clearIdx == CLR_LAST) begin
                        r_dataOut <= '0;
                        r_cmdDone <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cmdDone <= 1'b1;
                end
            endcase
        end
    end

    assign memCmdDone = r_cmdDone;
    assign memDataOut = r_dataOut;

endmodule

// File: tb/tb_mem_cmd_responder.sv
module tb_mem_cmd_responder;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    logic        clk;
    logic        rstN;
    logic [1:0]  memCmd;
    logic [63:0] memAddrIn;
    logic [31:0] ioDataIn;
    logic        ioCmdDoneIn;
    logic        memCmdDone;
    logic [31:0] memDataOut;
`ifdef MEM_RANGE_ERR_EN
    logic        memErr;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_cmd_responder #(.DATA_W(32), .ADDR_W(64), .DEPTH(256)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .memCmd      (memCmd),
        .memAddrIn   (memAddrIn),
        .ioDataIn    (ioDataIn),
        .ioCmdDoneIn (ioCmdDoneIn),
        .memCmdDone  (memCmdDone),
`ifdef MEM_RANGE_ERR_EN
        .memErr      (memErr),
`endif
        .memDataOut  (memDataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one command and pulses ioCmdDoneIn. It then counts the
    // low cycles of memCmdDone. On return the bench sits at the first
    // falling edge where memCmdDone is high again.
    task automatic run_cmd(input logic [1:0] cmd, input logic [63:0] addr,
                           input logic [31:0] data, input int exp_low, input string tag);
        int low;
        @(negedge clk);
        memCmd      = cmd;
        memAddrIn   = addr;
        ioDataIn    = data;
        ioCmdDoneIn = 1'b1;
        @(negedge clk);
        ioCmdDoneIn = 1'b0;
        low = 0;
        while (memCmdDone == 1'b0 && low < 1000) begin
            low++;
            @(negedge clk);
        end
        chk({tag, " busy"}, 64'(low), 64'(exp_low));
    endtask

    task automatic rd(input logic [63:0] addr, input logic [31:0] exp, input string tag);
        run_cmd(READ, addr, 32'h0, 1, tag);
        chk({tag, " data"}, 64'(memDataOut), 64'(exp));
    endtask

    initial begin
        int low;
        rstN        = 1'b0;
        memCmd      = NOP;
        memAddrIn   = '0;
        ioDataIn    = '0;
        ioCmdDoneIn = 1'b0;

        // Reset state
        #12;
        chk("rst done", 64'(memCmdDone), 64'd1);
        chk("rst data", 64'(memDataOut), 64'd0);
`ifdef MEM_RANGE_ERR_EN
        chk("rst err", 64'(memErr), 64'd0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle done", 64'(memCmdDone), 64'd1);
        chk("idle data", 64'(memDataOut), 64'd0);

        // Write, then read back
        run_cmd(WRITE, 64'h0F, 32'hA5A5_0001, 1, "wr 0f");
        rd(64'h0F, 32'hA5A5_0001, "rd 0f");

        // A NOP leaves the block idle and keeps the read data
        run_cmd(NOP, 64'h0F, 32'h0, 0, "nop");
        chk("nop data", 64'(memDataOut), 64'hA5A5_0001);

        // CLEAR after writing the lowest and highest words
        run_cmd(WRITE, 64'h00, 32'hDEAD_0000, 1, "wr 00");
        run_cmd(WRITE, 64'hFF, 32'hBEEF_00FF, 1, "wr ff");
        rd(64'h00, 32'hDEAD_0000, "rd 00");
        rd(64'hFF, 32'hBEEF_00FF, "rd ff");
        run_cmd(CLEAR, 64'h0, 32'h0, 256, "clear");
        chk("clear data", 64'(memDataOut), 64'd0);
        rd(64'h00, 32'h0, "rd 00 clr");
        rd(64'hFF, 32'h0, "rd ff clr");

        // A start edge during CLEAR is ignored. The level is held high
        // through completion and must not start a new command.
        run_cmd(WRITE, 64'h10, 32'h5555_0010, 1, "wr 10");
        @(negedge clk);
        memCmd      = CLEAR;
        ioCmdDoneIn = 1'b1;
        @(negedge clk);
        ioCmdDoneIn = 1'b0;
        low = 0;
        while (memCmdDone == 1'b0 && low < 1000) begin
            low++;
            if (low == 10) begin
                memCmd      = WRITE;
                memAddrIn   = 64'h10;
                ioDataIn    = 32'h0000_1234;
                ioCmdDoneIn = 1'b1;
            end
            @(negedge clk);
        end
        chk("clear busy2", 64'(low), 64'd256);
        repeat (3) @(negedge clk);
        chk("held level", 64'(memCmdDone), 64'd1);
        ioCmdDoneIn = 1'b0;
        rd(64'h10, 32'h0, "rd 10");

        // Out-of-range addresses
        run_cmd(WRITE, 64'h00, 32'h0000_1111, 1, "wr 00b");
        run_cmd(WRITE, 64'h1_0000_0000, 32'h0000_FFFF, 1, "wr oor");
`ifdef MEM_RANGE_ERR_EN
        chk("err wr oor", 64'(memErr), 64'd1);
`endif
        rd(64'h00, 32'h0000_1111, "rd 00b");
`ifdef MEM_RANGE_ERR_EN
        chk("err rd ok", 64'(memErr), 64'd0);
`endif
        rd(64'h1_0000_0000, 32'h0, "rd oor");
`ifdef MEM_RANGE_ERR_EN
        chk("err rd oor", 64'(memErr), 64'd1);
`endif
        rd(64'h01, 32'h0, "rd 01");
`ifdef MEM_RANGE_ERR_EN
        chk("err rd 01", 64'(memErr), 64'd0);
`endif
        run_cmd(WRITE, 64'hFF, 32'h0000_00FF, 1, "wr ff2");
        run_cmd(WRITE, 64'h100, 32'h0000_2222, 1, "wr 100");
        rd(64'hFF, 32'h0000_00FF, "rd ff2");
        rd(64'h00, 32'h0000_1111, "rd 00c");

        // Reset during CLEAR
        run_cmd(WRITE, 64'h05, 32'hAAAA_0005, 1, "wr 05");
        run_cmd(WRITE, 64'hC8, 32'hCCCC_00C8, 1, "wr c8");
        @(negedge clk);
        memCmd      = CLEAR;
        ioCmdDoneIn = 1'b1;
        @(negedge clk);
        ioCmdDoneIn = 1'b0;
        repeat (99) @(negedge clk);
        chk("clr mid busy", 64'(memCmdDone), 64'd0);
        rstN = 1'b0;
        #1;
        chk("abort done", 64'(memCmdDone), 64'd1);
        chk("abort data", 64'(memDataOut), 64'd0);
        @(negedge clk);
        rstN = 1'b1;
        rd(64'h05, 32'h0, "rd 05");
        rd(64'hC8, 32'hCCCC_00C8, "rd c8");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
